// File: rtl/adc_spi_rx_sfr.sv
// SFR-mapped reader for a 12-bit serial ADC (16-clock frame, 4 leading zeros, MSB first).
// Launches frames from a control SFR, latches the result into two read-only SFRs, raises an IRQ.
module adc_spi_rx_sfr #(
    parameter logic [7:0] CTRL_ADDRS = 8'hC4,
    parameter logic [7:0] DATH_ADDRS = 8'hC5,
    parameter logic [7:0] DATL_ADDRS = 8'hC6,
    parameter int         CLK_DIV    = 4,
    parameter int         QUIET_CYC  = 8
) (
    input  logic       CPUClock,
    input  logic       RESET,
    input  logic [7:0] DIR_WR_ADDRS,
    input  logic [7:0] DIR_RD_ADDRS,
    input  logic [7:0] WR_DATA,
    input  logic       DIRECT_WR,
    input  logic       WR_EN,
    input  logic       DIRECT_RD,
    output logic [7:0] RD_DATA,
    output logic       HIT,
    output logic       ADC_CS_n,
    output logic       ADC_SCLK,
    input  logic       ADC_SDO,
    output logic       ADC_INT_REQ,
    input  logic       IACK_ADC
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_QUIET = 3'd4;

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_M1 = 8'(QUIET_CYC - 1);

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [4:0]  bitcnt;
    logic [11:0] shreg;
    logic [11:0] res;
    logic        sync1, sync2;
    logic        cs_n, sclk;
    logic        done, ovr, ie, cont;

    logic ctrl_wr, abort, start, phase_end, complete, done_clr, busy;

    assign ctrl_wr   = DIRECT_WR & WR_EN & (DIR_WR_ADDRS == CTRL_ADDRS);
    assign abort     = ctrl_wr & WR_DATA[3];
    assign start     = ctrl_wr & WR_DATA[0] & (state == S_IDLE);
    assign phase_end = (cnt == 8'd0);
    assign busy      = (state != S_IDLE);
    assign complete  = !abort && (state == S_HIGH) && phase_end && (bitcnt == 5'd16);
    assign done_clr  = IACK_ADC | (DIRECT_RD & (DIR_RD_ADDRS == DATL_ADDRS))
                     | (ctrl_wr & ~WR_DATA[7]);

    always_ff @(posedge CPUClock or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ADC_SDO;
            sync2 <= sync1;
        end
    end

    // 12-bit shifter: after 16 samples only the last 12 remain, dropping the leading zeros.
    always_ff @(posedge CPUClock or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            bitcnt <= 5'd0;
            shreg  <= 12'h000;
            cs_n   <= 1'b1;
            sclk   <= 1'b1;
        end else if (abort) begin
            state  <= S_IDLE;
            cnt    <= 8'd0;
            bitcnt <= 5'd0;
            shreg  <= 12'h000;
            cs_n   <= 1'b1;
            sclk   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_SETUP;
                        cs_n   <= 1'b0;
                        cnt    <= DIV_M1;
                        bitcnt <= 5'd0;
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        shreg  <= {shreg[10:0], sync2};
                        state  <= S_LOW;
                        sclk   <= 1'b0;
                        cnt    <= DIV_M1;
                        bitcnt <= bitcnt + 5'd1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        state <= S_HIGH;
                        sclk  <= 1'b1;
                        cnt   <= DIV_M1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HIGH: begin
                    if (!phase_end) begin
                        cnt <= cnt - 8'd1;
                    end else if (bitcnt != 5'd16) begin
                        shreg  <= {shreg[10:0], sync2};
                        state  <= S_LOW;
                        sclk   <= 1'b0;
                        cnt    <= DIV_M1;
                        bitcnt <= bitcnt + 5'd1;
                    end else begin
                        state <= S_QUIET;
                        cs_n  <= 1'b1;
                        cnt   <= QUIET_M1;
                    end
                end
                S_QUIET: begin
                    if (!phase_end) begin
                        cnt <= cnt - 8'd1;
                    end else if (cont) begin
                        state  <= S_SETUP;
                        cs_n   <= 1'b0;
                        cnt    <= DIV_M1;
                        bitcnt <= 5'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b1;
                end
            endcase
        end
    end

    // A completion wins over a coincident DONE clear, and then leaves OVR alone.
    always_ff @(posedge CPUClock or posedge RESET) begin
        if (RESET) begin
            res  <= 12'h000;
            done <= 1'b0;
            ovr  <= 1'b0;
            ie   <= 1'b0;
            cont <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ie   <= WR_DATA[2];
                cont <= WR_DATA[1];
                if (!WR_DATA[6])
                    ovr <= 1'b0;
            end
            if (complete) begin
                res  <= shreg;
                done <= 1'b1;
                if (done && !done_clr)
                    ovr <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end
        end
    end

    assign ADC_CS_n    = cs_n;
    assign ADC_SCLK    = sclk;
    assign ADC_INT_REQ = done & ie;

    always_comb begin
        RD_DATA = 8'h00;
        HIT     = 1'b0;
        if (DIR_RD_ADDRS == CTRL_ADDRS) begin
            HIT     = 1'b1;
            RD_DATA = {done, ovr, 2'b00, 1'b0, ie, cont, busy};
        end else if (DIR_RD_ADDRS == DATH_ADDRS) begin
            HIT     = 1'b1;
            RD_DATA = {4'b0000, res[11:8]};
        end else if (DIR_RD_ADDRS == DATL_ADDRS) begin
            HIT     = 1'b1;
            RD_DATA = res[7:0];
        end
    end

endmodule
